// File: rtl/striping_if.sv
// Source-to-striper bundle: one input word stream in, two half-rate lanes
// plus phase, pair strobe and per-lane word counters out.
interface striping_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              clear_cnt;
  logic [DATA_W-1:0] lane_0;
  logic              valid_0;
  logic [DATA_W-1:0] lane_1;
  logic              valid_1;
  logic              selector;
  logic              lane_strobe;
  logic [CNT_W-1:0]  count_0;
  logic [CNT_W-1:0]  count_1;

  modport master (
    output data_in, valid_in, clear_cnt,
    input  lane_0, valid_0, lane_1, valid_1, selector, lane_strobe,
           count_0, count_1
  );

  modport slave (
    input  data_in, valid_in, clear_cnt,
    output lane_0, valid_0, lane_1, valid_1, selector, lane_strobe,
           count_0, count_1
  );
endinterface

// File: rtl/striping.sv
// Two-lane striper: alternate clk_2f slots go to lane_0 (even) and lane_1 (odd),
// each lane word held two cycles, with per-lane valid-word counters.
module striping #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic      clk_2f,
  input  logic      reset,
  striping_if.slave bus
);

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } phase_t;

  phase_t state_reg, state_next;
  logic   strobe_reg, strobe_next;

  logic [2*DATA_W-1:0] lane_flat;
  logic [1:0]          valid_flat;
  logic [2*CNT_W-1:0]  count_flat;

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      state_reg  <= EVEN;
      strobe_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      strobe_reg <= strobe_next;
    end
  end

  // The phase never waits on valid_in so it stays locked to the receiver.
  always_comb begin
    state_next  = EVEN;
    strobe_next = 1'b0;
    case (state_reg)
      EVEN: begin
        state_next  = ODD;
        strobe_next = 1'b0;
      end
      ODD: begin
        state_next  = EVEN;
        strobe_next = 1'b1;
      end
    endcase
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic [DATA_W-1:0] lane_reg, lane_next;
    logic              valid_reg, valid_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              slot_hit;

    assign slot_hit = (state_reg == ((gi == 0) ? EVEN : ODD));

    always_comb begin
      lane_next  = lane_reg;
      valid_next = valid_reg;
      count_next = count_reg;
      if (slot_hit) begin
        lane_next  = bus.valid_in ? bus.data_in : '0;
        valid_next = bus.valid_in;
      end
      // Clear wins over a same-cycle increment.
      if (bus.clear_cnt) begin
        count_next = '0;
      end else if (slot_hit && bus.valid_in) begin
        count_next = count_reg + 1'b1;
      end
    end

    always_ff @(posedge clk_2f or posedge reset) begin
      if (reset) begin
        lane_reg  <= '0;
        valid_reg <= 1'b0;
        count_reg <= '0;
      end else begin
        lane_reg  <= lane_next;
        valid_reg <= valid_next;
        count_reg <= count_next;
      end
    end

    assign lane_flat[gi*DATA_W +: DATA_W] = lane_reg;
    assign valid_flat[gi]                 = valid_reg;
    assign count_flat[gi*CNT_W +: CNT_W]  = count_reg;
  end

  assign bus.lane_0      = lane_flat[DATA_W-1:0];
  assign bus.lane_1      = lane_flat[2*DATA_W-1:DATA_W];
  assign bus.valid_0     = valid_flat[0];
  assign bus.valid_1     = valid_flat[1];
  assign bus.count_0     = count_flat[CNT_W-1:0];
  assign bus.count_1     = count_flat[2*CNT_W-1:CNT_W];
  assign bus.selector    = (state_reg == ODD);
  assign bus.lane_strobe = strobe_reg;

endmodule

// File: doc/striping.md
Name: striping

Overview:
- Transmit-side counterpart of the two-lane un-striping receiver.
- Takes one 32-bit word stream at clk_2f and distributes consecutive clock slots alternately onto lane_0 and lane_1.
- Each lane word is held for two clk_2f cycles, so the lanes can be sampled at half rate.
- Sits between the serialised data source and the two lane paths, and keeps per-lane word counters for link checking.

Parameters:
- DATA_W, 32, width of data_in, lane_0 and lane_1.
- CNT_W, 16, width of the per-lane valid-word counters.

Ports:
- clk_2f  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- data_in  input  DATA_W  input word for the current slot.
- valid_in  input  1  data_in carries a real word this cycle.
- clear_cnt  input  1  synchronous clear of both counters.
- lane_0  output  DATA_W  even-slot word, registered.
- valid_0  output  1  lane_0 holds a real word.
- lane_1  output  DATA_W  odd-slot word, registered.
- valid_1  output  1  lane_1 holds a real word.
- selector  output  1  current slot phase: 0 = even slot, 1 = odd slot.
- lane_strobe  output  1  high for one cycle when lane_1 has just been updated, i.e. a complete pair is presented.
- count_0  output  CNT_W  valid words sent on lane 0.
- count_1  output  CNT_W  valid words sent on lane 1.

Behaviour:
- Reset (async, active-high):
  - lane_0 = 0, lane_1 = 0.
  - valid_0, valid_1, selector, lane_strobe = 0.
  - count_0 = 0, count_1 = 0.
  - Applies mid-operation too: outputs drop in the same cycle, not at the next edge.
- Phase state machine (two states):
  - EVEN (selector = 0) and ODD (selector = 1).
  - Toggles on every clk_2f edge out of reset, whether or not valid_in is high.
  - The phase never stalls, so it stays aligned with a receiver that also toggles unconditionally.
  - The first edge after reset release samples in EVEN.
- EVEN edge:
  - valid_in = 1: lane_0 <= data_in, valid_0 <= 1.
  - valid_in = 0: lane_0 <= 0, valid_0 <= 0.
  - lane_1 and valid_1 hold their values.
- ODD edge:
  - Same rule applied to lane_1 / valid_1.
  - lane_0 and valid_0 hold their values.
- Latency: a word sampled at edge n appears on its lane after edge n, and holds until edge n+2, i.e. two cycles.
- lane_strobe:
  - Registered; equals 1 after every ODD edge and 0 after every EVEN edge.
  - This places it in the same cycle that the updated lane_1 becomes visible.
- No backpressure: the source must present one word per slot or drop valid_in. Words offered while valid_in = 0 are discarded.
- Counters:
  - count_0 increments after an EVEN edge with valid_in = 1; count_1 after an ODD edge with valid_in = 1.
  - Both wrap modulo 2^CNT_W with no saturation and no flag.
  - clear_cnt = 1 zeroes both counters at the next edge; clear takes priority over increment in the same cycle.
  - Lane data is unaffected by clear_cnt.
- Odd-length bursts: a final word landing in EVEN leaves the following ODD slot invalid (valid_1 = 0, lane_1 = 0). No padding is inserted.
- Round trip: un-striping driven by lane_0/lane_1/valid_0/valid_1 and reset together must reproduce the original sequence, with invalid slots appearing as valid_out = 0 and data 0.

Test Plan:
1. Reset held, then released; drive valid_in = 1 with data_in = 0xA0000001, 0xA0000002, 0xA0000003, 0xA0000004 on consecutive edges.
   - Required: lane_0 = 0xA0000001 for cycles 1–2, then 0xA0000003.
   - Required: lane_1 = 0xA0000002, then 0xA0000004.
   - Required: selector toggles 0,1,0,1; count_0 = 2, count_1 = 2.
2. Drive valid_in pattern 1,0,1,1 with data_in 0x11, 0x22, 0x33, 0x44.
   - Required: valid_1 = 0 and lane_1 = 0 for the second slot; lane_0 = 0x33; lane_1 = 0x44.
   - Required: count_0 = 2, count_1 = 1.
3. Odd burst of 3 words 0xB1, 0xB2, 0xB3, then valid_in = 0.
   - Required: lane_0 = 0xB3 with valid_0 = 1, followed by valid_1 = 0 and lane_1 = 0.
   - Required: selector keeps toggling.
4. Assert reset asynchronously between edges during a stream.
   - Required: all outputs become 0 before the next edge.
   - Required: after release, the first sample lands on lane_0.
5. Preload count_0 = 0xFFFF via continuous EVEN-valid traffic, then send one more EVEN word.
   - Required: count_0 = 0x0000.
   - Then assert clear_cnt together with a valid ODD word: required count_1 = 0.
6. Loopback with un-striping on a shared clk_2f/reset, random data with 30% invalid slots.
   - Required: data_out/valid_out reproduce the input sequence, with invalid slots as valid_out = 0 and data 0.
